// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: latches a hex value, decodes each
// nibble to active-low segments with leading-zero blanking and blinking, and
// rotates an active-low one-hot digit select.

module disp_scan_digit (
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    logic [6:0] hex;

    always_comb begin
        hex = 7'h7F;
        case (nib_i)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end

    assign seg_o = blank_i ? 7'h7F : hex;
endmodule

module disp_scan_ctrl #(
    parameter int CLK_DIV     = 50000,
    parameter int BLINK_TICKS = 128,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  blink_en,
    output logic [3:0]  sel,
    output logic [6:0]  di3,
    output logic [6:0]  di2,
    output logic [6:0]  di1,
    output logic [6:0]  di0
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS - 1);

    logic [15:0]     val_q, val_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            phase_q, phase_d;
    logic [3:0]      sel_q, sel_d;
    logic [3:0][6:0] di_q, seg;
    logic [3:0]      lz, blank;
    logic            tick;

    always_comb begin
        tick    = (pre_q == PRE_MAX);
        val_d   = load ? value : val_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        ptr_d   = tick ? ptr_q + 2'd1 : ptr_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick) begin
            if (bcnt_q == BLK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        // Select tracks the pointer's next value so both move on the tick edge.
        sel_d = ~(4'b0001 << ptr_d);
    end

    // Blink-off takes priority over leading-zero blanking; digit 0 never blanks as a leading zero.
    for (genvar k = 0; k < 4; k++) begin : g_dig
        if (k == 0) begin : g_lsd
            assign lz[k] = 1'b0;
        end else begin : g_upper
            assign lz[k] = (BLANK_LZ != 0) && (val_q[15:4*k] == '0);
        end
        assign blank[k] = (blink_en[k] & phase_q) | lz[k];
        disp_scan_digit u_dig (
            .nib_i   (val_q[4*k +: 4]),
            .blank_i (blank[k]),
            .seg_o   (seg[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q   <= '0;
            pre_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            sel_q   <= 4'b1110;
            di_q    <= {4{7'h7F}};
        end else begin
            val_q   <= val_d;
            pre_q   <= pre_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
            di_q    <= seg;
        end
    end

    assign sel = sel_q;
    assign di0 = di_q[0];
    assign di1 = di_q[1];
    assign di2 = di_q[2];
    assign di3 = di_q[3];
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with CLK_DIV=4, BLINK_TICKS=2; a second
// instance with leading-zero blanking disabled shares the same stimulus.

module tb_disp_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blink_en;
    logic [3:0]  sel, sel_b;
    logic [6:0]  di3, di2, di1, di0;
    logic [6:0]  b_di3, b_di2, b_di1, b_di0;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    logic [3:0] prev_sel;

    disp_scan_ctrl #(.CLK_DIV(4), .BLINK_TICKS(2), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blink_en(blink_en),
        .sel(sel), .di3(di3), .di2(di2), .di1(di1), .di0(di0)
    );

    disp_scan_ctrl #(.CLK_DIV(4), .BLINK_TICKS(2), .BLANK_LZ(0)) dut_nlz (
        .clk(clk), .rst(rst), .value(value), .load(load), .blink_en(blink_en),
        .sel(sel_b), .di3(b_di3), .di2(b_di2), .di1(b_di1), .di0(b_di0)
    );

    always #5 clk = ~clk;

    // Edge n after reset release: slot index n/4, blink phase flips every 8 edges.
    function automatic logic [3:0] exp_sel(input int n);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((n / 4) % 4));
    endfunction

    function automatic bit exp_off(input int n);
        return (n >= 1) && ((((n - 1) / 8) % 2) == 1);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_di(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                          input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, "_di3"}, {9'd0, di3}, {9'd0, e3});
        chk({tag, "_di2"}, {9'd0, di2}, {9'd0, e2});
        chk({tag, "_di1"}, {9'd0, di1}, {9'd0, e1});
        chk({tag, "_di0"}, {9'd0, di0}, {9'd0, e0});
    endtask

    task automatic load_val(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; value = '0; load = 1'b0; blink_en = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", {12'd0, sel}, 16'h000E);
        chk_di("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        rst = 1'b0;
        cyc = 0;

        // 1: idle scan
        step();
        chk("t1_sel_first", {12'd0, sel}, 16'h000E);
        chk_di("t1_first", 7'h7F, 7'h7F, 7'h7F, 7'h40);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t1_sel_scan", {12'd0, sel}, {12'd0, exp_sel(cyc)});
        end
        chk("t1_sel_frame", {12'd0, sel}, 16'h000E);

        // 2: full decode table
        load_val(16'hA5C3); chk_di("t2_a5c3", 7'h08, 7'h12, 7'h46, 7'h30);
        load_val(16'h1234); chk_di("t2_1234", 7'h79, 7'h24, 7'h30, 7'h19);
        load_val(16'h89EF); chk_di("t2_89ef", 7'h00, 7'h10, 7'h06, 7'h0E);
        load_val(16'hBD67); chk_di("t2_bd67", 7'h03, 7'h21, 7'h02, 7'h78);

        // 3: leading-zero blanking
        load_val(16'h0050);
        chk_di("t3_0050", 7'h7F, 7'h7F, 7'h12, 7'h40);
        chk("t3_nlz_di3", {9'd0, b_di3}, 16'h0040);
        chk("t3_nlz_di2", {9'd0, b_di2}, 16'h0040);
        chk("t3_nlz_di1", {9'd0, b_di1}, 16'h0012);
        load_val(16'h0000);
        chk_di("t3_0000", 7'h7F, 7'h7F, 7'h7F, 7'h40);

        // 4: blink on digit 0
        value = 16'h1234; load = 1'b1; blink_en = 4'b0001;
        step();
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_blink_di0", {9'd0, di0}, exp_off(cyc) ? 16'h007F : 16'h0019);
            chk("t4_blink_di1", {9'd0, di1}, 16'h0030);
            chk("t4_blink_di3", {9'd0, di3}, 16'h0079);
        end
        for (int i = 0; i < 16 && !exp_off(cyc); i++) step();
        chk("t4_off_reached", {9'd0, di0}, 16'h007F);
        blink_en = 4'b0000;
        step();
        chk("t4_unblink", {9'd0, di0}, 16'h0019);

        // 5: load in the tick cycle
        while ((cyc + 1) % 4 != 0) step();
        prev_sel = sel;
        value = 16'hFFFF; load = 1'b1;
        step();
        load = 1'b0;
        chk("t5_sel_adv", {12'd0, sel}, {12'd0, exp_sel(cyc)});
        chk("t5_sel_moved", {15'd0, sel != prev_sel}, 16'h0001);
        step();
        chk_di("t5_ffff", 7'h0E, 7'h0E, 7'h0E, 7'h0E);
        prev_sel = sel;
        step(); step();
        chk("t5_sel_hold", {12'd0, sel}, {12'd0, prev_sel});
        step();
        chk("t5_sel_next", {12'd0, sel}, {12'd0, exp_sel(cyc)});

        // 6: async reset while sel=1011 and blinking digit 0 is off
        blink_en = 4'b0001;
        for (int i = 0; i < 64 && !(exp_sel(cyc) == 4'b1011 && exp_off(cyc)); i++) step();
        chk("t6_pre_sel", {12'd0, sel}, 16'h000B);
        chk_di("t6_pre", 7'h0E, 7'h0E, 7'h0E, 7'h7F);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_sel", {12'd0, sel}, 16'h000E);
        chk_di("t6_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("t6_rst_nlz_di3", {9'd0, b_di3}, 16'h007F);
        #1;
        rst = 1'b0;
        cyc = 0;
        step();
        chk("t6_post_sel", {12'd0, sel}, 16'h000E);
        chk_di("t6_post", 7'h7F, 7'h7F, 7'h7F, 7'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Four-digit seven-segment scan controller for the calculator display path. It latches a 16-bit hex value and decodes each nibble to active-low segment patterns, with optional leading-zero blanking and per-digit blinking. It also rotates an active-low one-hot digit select at a programmable refresh rate. Its `di3..di0` and `sel` outputs drive the downstream 4:1 display multiplexer directly, and `sel` also drives the board anodes.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot. Legal range is 1..2^20.
- `BLINK_TICKS`, 128: scan ticks per blink half-period. Legal range is 1..2^16.
- `BLANK_LZ`, 1: when 1, leading zeros are blanked; digit 0 is never blanked by this rule.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `value` input, 16 bits: hex value to display; nibble k maps to digit k.
- `load` input, 1 bit: capture strobe; `value` is sampled on the rising edge where `load`=1.
- `blink_en` input, 4 bits: bit k=1 makes digit k blink.
- `sel` output, 4 bits: registered active-low one-hot digit select.
- `di3`, `di2`, `di1`, `di0` outputs, 7 bits each: registered segment patterns, bit order {g,f,e,d,c,b,a}, active-low (0 = lit).

## Operation
- **Value register `val_r`:** loads `value` on any edge with `load`=1 and holds otherwise. It does not depend on scan state.
- **Prescaler:** counts 0..CLK_DIV-1. `tick` is asserted in the cycle where count = CLK_DIV-1, and the count then wraps to 0. With CLK_DIV=1, `tick` is asserted every cycle.
- **Digit pointer `ptr`:** 2 bits, advances by one on each `tick` with wrap 3→0.
- **Select:** `sel` is registered as ~(1<<ptr_next), so it follows the sequence 1110→1101→1011→0111→1110. Exactly one bit of `sel` is 0 at all times.
- **Blink:**
  - A tick counter counts 0..BLINK_TICKS-1 on `tick` only.
  - At wrap, `phase` toggles.
  - `phase`=1 means the blinking digits are off.
- **Decode, registered every cycle from `val_r`.**
  - Hex table: 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
  - Blank pattern is 7'h7F.
  - Priority order:
    1. If `blink_en[k]`=1 and `phase`=1, `di_k` = 7F.
    2. Else if `BLANK_LZ`=1, k>0, and nibbles k..3 are all zero, `di_k` = 7F.
    3. Else `di_k` = table[nibble k].
- **Reset values:**
  - `val_r`=0, prescaler=0, `ptr`=0, blink counter=0, `phase`=0.
  - `sel`=4'b1110, `di3..di0`=7'h7F.
  - Reset asserted mid-scan or mid-blink restores all of these immediately and asynchronously.
  - After reset release, the first edge produces `di0`=40 (displays "0") and `di1..di3`=7F when `BLANK_LZ`=1.

## Timing
- **Load to outputs:** with `load` high at edge N, `val_r` updates at N and `di_k` reflects it at edge N+1, giving 1-cycle latency. Back-to-back loads each take effect, last writer wins.
- **Select update:** `sel` changes on the same edge on which `tick` is sampled high. It is stable for exactly CLK_DIV cycles per slot, and a full frame is 4·CLK_DIV cycles.
- **Blink timing:** the blink half-period is BLINK_TICKS·CLK_DIV cycles. `di_k` changes one edge after `phase` toggles.
- **Blink enable:** a change of `blink_en` affects `di` on the next edge. There is no synchronisation to the frame.
- **Simultaneous load and tick:** both are applied on the same edge with no interaction.
- **Prescaler independence:** `load` never resets the prescaler, the pointer, or the blink state.

## Test plan
Unless stated otherwise, the bench uses CLK_DIV=4, BLINK_TICKS=2, BLANK_LZ=1.

1. **Reset and idle scan.** Apply reset, then release it.
   - After release, `sel`=1110 and `di0`=40 with `di1..di3`=7F.
   - `sel` must step 1101 after 4 cycles, then 1011 and 0111, and return to 1110 after 16 cycles.
2. **Full decode.** Load 16'hA5C3.
   - One cycle later: `di3`=08, `di2`=12, `di1`=46, `di0`=30.
   - Repeat with 16'h1234 (expect 79, 24, 30, 19), 16'h89EF (expect 00, 10, 06, 0E) and 16'hBD67 (expect 03, 21, 02, 78), so that all 16 table entries are covered.
3. **Leading-zero blanking.**
   - Load 16'h0050: expect `di3`=7F, `di2`=7F, `di1`=12, `di0`=40.
   - Load 16'h0000: expect only `di0`=40.
   - Rebuild with BLANK_LZ=0 and load 16'h0050: expect `di3`=40, `di2`=40.
4. **Blink.** Load 16'h1234 with `blink_en`=4'b0001.
   - `di0` alternates between 19 and 7F every 8 cycles.
   - `di1..di3` stay constant.
   - Setting `blink_en`=0 while off restores 19 on the next edge.
5. **Simultaneous load and tick.** Assert `load` with 16'hFFFF in the tick cycle.
   - `sel` advances on the same edge.
   - All `di`=0E one edge later.
   - Scan cadence is unchanged, with the next `sel` step 4 cycles later.
6. **Mid-operation reset.** Assert `rst` asynchronously, between edges, while `sel`=1011 and the display is in a blink-off phase.
   - `sel`=1110 and all `di`=7F immediately, without waiting for an edge.
   - After release, `di0`=40 on the first edge.
